// File: rtl/axi_riscv_amos_pkg.sv
// Shared types and ATOP decode for the pipelined AMO lane ALU.
package axi_riscv_amos_pkg;

    typedef enum logic [3:0] {
        AMO_ADD  = 4'd0,
        AMO_CLR  = 4'd1,
        AMO_EOR  = 4'd2,
        AMO_SET  = 4'd3,
        AMO_SMAX = 4'd4,
        AMO_SMIN = 4'd5,
        AMO_UMAX = 4'd6,
        AMO_UMIN = 4'd7,
        AMO_SWAP = 4'd8,
        AMO_NOP  = 4'd9
    } amo_lane_op_e;

    // Little-endian store/load atomics map [2:0] straight onto the first eight ops.
    function automatic amo_lane_op_e amo_decode(input logic [5:0] atop);
        amo_lane_op_e op;
        case (atop[5:4])
            2'b11: begin
                if (atop[3:0] == 4'b0000) begin
                    op = AMO_SWAP;
                end else begin
                    op = AMO_NOP;
                end
            end
            2'b01, 2'b10: begin
                if (atop[3]) begin
                    op = AMO_NOP;
                end else begin
                    op = amo_lane_op_e'({1'b0, atop[2:0]});
                end
            end
            default: op = AMO_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/axi_riscv_amos_lane_alu.sv
// Combinational lane extract, AMO compute and merge back into the bus word.
// AXI_RISCV_AMOS_ALU_ILLEGAL_CHECK_EN adds the illegal-operation flag.
module axi_riscv_amos_lane_alu
    import axi_riscv_amos_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int OFF_W      = $clog2(DATA_WIDTH/8)
) (
    input  logic [5:0]              amo_op_i,
    input  logic [2:0]              size_i,
    input  logic [OFF_W-1:0]        addr_off_i,
    input  logic [DATA_WIDTH-1:0]   operand_a_i,
    input  logic [DATA_WIDTH-1:0]   operand_b_i,
    output logic [DATA_WIDTH-1:0]   result_o,
    output logic [DATA_WIDTH/8-1:0] strb_o,
    output logic                    err_o
);

    localparam int NB        = DATA_WIDTH / 8;
    localparam int LOG_BYTES = $clog2(NB);

    amo_lane_op_e          op_s;
    int                    lane_bytes_s;
    int                    lane_bits_s;
    int                    off_s;
    logic [DATA_WIDTH-1:0] low_mask_s;
    logic [DATA_WIDTH-1:0] sign_mask_s;
    logic [DATA_WIDTH-1:0] lane_mask_s;
    logic [DATA_WIDTH-1:0] a_sh_s;
    logic [DATA_WIDTH-1:0] b_sh_s;
    logic [DATA_WIDTH-1:0] a_ext_s;
    logic [DATA_WIDTH-1:0] b_ext_s;
    logic [DATA_WIDTH-1:0] res_s;
    logic [NB-1:0]         lane_strb_s;
    logic                  signed_s;
    logic                  a_neg_s;
    logic                  b_neg_s;
    logic                  lt_s;
    logic                  bad_s;

    // Lane geometry, sign/zero extension, one wide compare, op select and merge.
    always_comb begin
        op_s = amo_decode(amo_op_i);
        if (int'(size_i) > LOG_BYTES) begin
            lane_bytes_s = NB;
        end else begin
            lane_bytes_s = 32'sd1 << int'(size_i);
        end
        lane_bits_s = lane_bytes_s * 32'sd8;
        off_s       = int'(addr_off_i) & ~(lane_bytes_s - 32'sd1);

        for (int i = 0; i < DATA_WIDTH; i++) begin
            low_mask_s[i]  = (i < lane_bits_s);
            sign_mask_s[i] = (i == lane_bits_s - 32'sd1);
        end
        for (int j = 0; j < NB; j++) begin
            lane_strb_s[j]       = (j >= off_s) && (j < off_s + lane_bytes_s);
            lane_mask_s[8*j +: 8] = {8{lane_strb_s[j]}};
        end

        a_sh_s   = operand_a_i >> (off_s * 32'sd8);
        b_sh_s   = operand_b_i >> (off_s * 32'sd8);
        signed_s = (op_s == AMO_SMAX) || (op_s == AMO_SMIN);
        a_neg_s  = signed_s && (|(a_sh_s & sign_mask_s));
        b_neg_s  = signed_s && (|(b_sh_s & sign_mask_s));
        a_ext_s  = (a_sh_s & low_mask_s) | (a_neg_s ? ~low_mask_s : {DATA_WIDTH{1'b0}});
        b_ext_s  = (b_sh_s & low_mask_s) | (b_neg_s ? ~low_mask_s : {DATA_WIDTH{1'b0}});
        // DATA_WIDTH+1-bit subtract: the extra top bit makes one compare serve both signednesses.
        lt_s     = $signed({a_neg_s, a_ext_s}) < $signed({b_neg_s, b_ext_s});

        case (op_s)
            AMO_ADD:  res_s = a_ext_s + b_ext_s;
            AMO_CLR:  res_s = a_ext_s & ~b_ext_s;
            AMO_EOR:  res_s = a_ext_s ^ b_ext_s;
            AMO_SET:  res_s = a_ext_s | b_ext_s;
            AMO_SMAX: res_s = lt_s ? b_ext_s : a_ext_s;
            AMO_UMAX: res_s = lt_s ? b_ext_s : a_ext_s;
            AMO_SMIN: res_s = lt_s ? a_ext_s : b_ext_s;
            AMO_UMIN: res_s = lt_s ? a_ext_s : b_ext_s;
            AMO_SWAP: res_s = b_ext_s;
            default:  res_s = a_ext_s;
        endcase

`ifdef AXI_RISCV_AMOS_ALU_ILLEGAL_CHECK_EN
        bad_s = (op_s == AMO_NOP) || (int'(size_i) > LOG_BYTES) ||
                ((int'(addr_off_i) & (lane_bytes_s - 32'sd1)) != 32'sd0);
        err_o = bad_s;
`else
        bad_s = (op_s == AMO_NOP);
        err_o = 1'b0;
`endif

        if (bad_s) begin
            result_o = operand_a_i;
            strb_o   = {NB{1'b0}};
        end else begin
            result_o = (operand_a_i & ~lane_mask_s) | ((res_s & low_mask_s) << (off_s * 32'sd8));
            strb_o   = lane_strb_s;
        end
    end

endmodule

// File: rtl/axi_riscv_amos_alu_pipe.sv
// Pipelined AMO ALU: lane ALU feeds PIPE_STAGES valid/ready register stages.
// AXI_RISCV_AMOS_ALU_ILLEGAL_CHECK_EN enables err_o in the lane ALU.
module axi_riscv_amos_alu_pipe
    import axi_riscv_amos_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [5:0]                      amo_op_i,
    input  logic [2:0]                      size_i,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] addr_off_i,
    input  logic [DATA_WIDTH-1:0]           operand_a_i,
    input  logic [DATA_WIDTH-1:0]           operand_b_i,
    input  logic [TAG_WIDTH-1:0]            tag_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DATA_WIDTH-1:0]           result_o,
    output logic [DATA_WIDTH/8-1:0]         strb_o,
    output logic [TAG_WIDTH-1:0]            tag_o,
    output logic                            err_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   result;
        logic [DATA_WIDTH/8-1:0] strb;
        logic [TAG_WIDTH-1:0]    tag;
        logic                    err;
    } payload_t;

    payload_t alu_s;

    axi_riscv_amos_lane_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_alu (
        .amo_op_i    (amo_op_i),
        .size_i      (size_i),
        .addr_off_i  (addr_off_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .result_o    (alu_s.result),
        .strb_o      (alu_s.strb),
        .err_o       (alu_s.err)
    );

    assign alu_s.tag = tag_i;

    if (PIPE_STAGES == 0) begin : g_comb
        assign in_ready_o  = out_ready_i;
        assign out_valid_o = in_valid_i;
        assign result_o    = alu_s.result;
        assign strb_o      = alu_s.strb;
        assign tag_o       = alu_s.tag;
        assign err_o       = alu_s.err;
    end else begin : g_pipe
        logic [PIPE_STAGES:0] ready_s;

        assign ready_s[PIPE_STAGES] = out_ready_i;

        for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
            logic     valid_q;
            payload_t data_q;
            logic     prev_valid_s;
            payload_t prev_data_s;

            if (k == 0) begin : g_first
                assign prev_valid_s = in_valid_i;
                assign prev_data_s  = alu_s;
            end else begin : g_next
                assign prev_valid_s = g_stage[k-1].valid_q;
                assign prev_data_s  = g_stage[k-1].data_q;
            end

            // A stage may take new data when empty or when its successor drains it.
            assign ready_s[k] = !valid_q || ready_s[k+1];

            // Stage register: payload only moves on a real transfer so held outputs stay stable.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                    data_q  <= {$bits(payload_t){1'b0}};
                end else if (ready_s[k]) begin
                    valid_q <= prev_valid_s;
                    if (prev_valid_s) begin
                        data_q <= prev_data_s;
                    end
                end
            end
        end

        assign in_ready_o  = ready_s[0];
        assign out_valid_o = g_stage[PIPE_STAGES-1].valid_q;
        assign result_o    = g_stage[PIPE_STAGES-1].data_q.result;
        assign strb_o      = g_stage[PIPE_STAGES-1].data_q.strb;
        assign tag_o       = g_stage[PIPE_STAGES-1].data_q.tag;
        assign err_o       = g_stage[PIPE_STAGES-1].data_q.err;
    end

endmodule

// File: tb/tb_axi_riscv_amos_alu_pipe.sv
// Scoreboard bench for axi_riscv_amos_alu_pipe (DATA_WIDTH=64, PIPE_STAGES=2).
module tb_axi_riscv_amos_alu_pipe;

`ifdef AXI_RISCV_AMOS_ALU_ILLEGAL_CHECK_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  amo_op;
    logic [2:0]  size;
    logic [2:0]  addr_off;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [3:0]  tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [7:0]  strb;
    logic [3:0]  tag_out;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] r;
        logic [7:0]  s;
        logic [3:0]  t;
        logic        e;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [2:0]  sz;
        logic [2:0]  off;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic [7:0]  s;
        logic        e;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    axi_riscv_amos_alu_pipe #(
        .DATA_WIDTH  (64),
        .PIPE_STAGES (2),
        .TAG_WIDTH   (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .amo_op_i    (amo_op),
        .size_i      (size),
        .addr_off_i  (addr_off),
        .operand_a_i (op_a),
        .operand_b_i (op_b),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .strb_o      (strb),
        .tag_o       (tag_out),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual_tag=%0h required=none", tag_out);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.r);
                chk("strb", {56'd0, strb}, {56'd0, e.s});
                chk("tag", {60'd0, tag_out}, {60'd0, e.t});
                chk("err", {63'd0, err}, {63'd0, e.e});
            end
        end
    end

    task automatic drive(input vec_t v, input logic [3:0] t);
        amo_op   = v.op;
        size     = v.sz;
        addr_off = v.off;
        op_a     = v.a;
        op_b     = v.b;
        tag      = t;
        in_valid = 1'b1;
    endtask

    task automatic issue(input vec_t v, input logic [3:0] t);
        int n;
        n = 0;
        drive(v, t);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end else begin
            exp_q.push_back('{v.r, v.s, t, v.e});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t sw;
        int n;
        vecs.push_back('{6'h14, 3'd2, 3'd4, 64'h80000000_00000001, 64'h00000001_00000000, 64'h00000001_00000001, 8'hF0, 1'b0});
        vecs.push_back('{6'h16, 3'd2, 3'd4, 64'h80000000_00000001, 64'h00000001_00000000, 64'h80000000_00000001, 8'hF0, 1'b0});
        vecs.push_back('{6'h20, 3'd0, 3'd0, 64'h00000000_000012FF, 64'h00000000_00000001, 64'h00000000_00001200, 8'h01, 1'b0});
        vecs.push_back('{6'h30, 3'd3, 3'd0, 64'h11111111_11111111, 64'hAAAABBBB_CCCCDDDD, 64'hAAAABBBB_CCCCDDDD, 8'hFF, 1'b0});
        vecs.push_back('{6'h21, 3'd1, 3'd2, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_0F0F0000, 64'hFFFFFFFF_F0F0FFFF, 8'h0C, 1'b0});
        vecs.push_back('{6'h12, 3'd0, 3'd7, 64'h55000000_00000000, 64'hFF000000_00000000, 64'hAA000000_00000000, 8'h80, 1'b0});
        vecs.push_back('{6'h13, 3'd2, 3'd0, 64'h12345678_000000F0, 64'hFFFFFFFF_0000000F, 64'h12345678_000000FF, 8'h0F, 1'b0});
        vecs.push_back('{6'h15, 3'd1, 3'd6, 64'h80000000_00000000, 64'h7FFF0000_00000000, 64'h80000000_00000000, 8'hC0, 1'b0});
        vecs.push_back('{6'h17, 3'd1, 3'd6, 64'h80000000_00000000, 64'h7FFF0000_00000000, 64'h7FFF0000_00000000, 8'hC0, 1'b0});
        vecs.push_back('{6'h20, 3'd3, 3'd0, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000002, 64'h00000000_00000001, 8'hFF, 1'b0});
        vecs.push_back('{6'h14, 3'd0, 3'd1, 64'h00000000_00008000, 64'h00000000_00008011, 64'h00000000_00008000, 8'h02, 1'b0});
        vecs.push_back('{6'h31, 3'd3, 3'd0, 64'h01234567_89ABCDEF, 64'h00000000_00000005, 64'h01234567_89ABCDEF, 8'h00, ILL});
        vecs.push_back('{6'h28, 3'd0, 3'd0, 64'h00000000_000000FE, 64'h00000000_00000001, 64'h00000000_000000FE, 8'h00, ILL});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        amo_op    = 6'h00;
        size      = 3'd0;
        addr_off  = 3'd0;
        op_a      = 64'd0;
        op_b      = 64'd0;
        tag       = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_strb", {56'd0, strb}, 64'd0);
        chk("rst_tag", {60'd0, tag_out}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back directed vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i], 4'(i));
        end
        repeat (5) @(posedge clk);
        #1;

        // Backpressure: two accepts fill the pipe, third waits for out_ready.
        sw = '{6'h30, 3'd3, 3'd0, 64'h0, 64'h0, 64'h0, 8'hFF, 1'b0};
        out_ready = 1'b0;
        sw.b = 64'hA1; sw.r = 64'hA1; issue(sw, 4'd1);
        sw.b = 64'hA2; sw.r = 64'hA2; issue(sw, 4'd2);
        sw.b = 64'hA3; sw.r = 64'hA3; drive(sw, 4'd3);
        @(negedge clk);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_tag", {60'd0, tag_out}, 64'd1);
        @(negedge clk);
        chk("stable_tag", {60'd0, tag_out}, 64'd1);
        chk("stable_result", result, 64'hA1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("freed_in_ready", {63'd0, in_ready}, 64'd1);
        chk("order_tag1", {60'd0, tag_out}, 64'd1);
        exp_q.push_back('{sw.r, sw.s, 4'd3, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("order_tag2", {60'd0, tag_out}, 64'd2);
        chk("order_valid2", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        chk("order_tag3", {60'd0, tag_out}, 64'd3);
        chk("order_valid3", {63'd0, out_valid}, 64'd1);
        repeat (4) @(posedge clk);
        #1;

        // Reset with two operations in flight.
        out_ready = 1'b0;
        sw.b = 64'hE1; drive(sw, 4'hE);
        @(posedge clk);
        #1;
        sw.b = 64'hE2; drive(sw, 4'hF);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("inflight_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_result", result, 64'd0);
        chk("async_rst_tag", {60'd0, tag_out}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_stale_valid", {63'd0, out_valid}, 64'd0);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_riscv_amos_alu_pipe.md
Name: axi_riscv_amos_alu_pipe

Overview:
- Pipelined, sub-word-aware RISC-V/AXI5 atomic ALU with valid/ready handshakes on input and output.
- Evaluates the AXI ATOP arithmetic on a single naturally aligned lane (1..DATA_WIDTH/8 bytes) selected by size and address offset.
- Returns the full-width merged write data plus a byte strobe.
- Sits between the AMO read-response path and the write-data generator in the AMO adapter, replacing the purely combinational ALU so the compare/add path can be retimed.

Parameters:
- DATA_WIDTH, 64, datapath width in bits; power of two, 32..1024.
- PIPE_STAGES, 1, register stages between in and out handshakes; 0 = combinational pass-through, max 3.
- TAG_WIDTH, 4, width of sideband tag carried unchanged alongside each operation.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  operation valid
- in_ready_o  out  1  operation accepted when valid&ready
- amo_op_i  in  6  AXI ATOP encoding
- size_i  in  3  AXI size; lane bytes = 2**size_i
- addr_off_i  in  $clog2(DATA_WIDTH/8)  byte offset of lane within bus word
- operand_a_i  in  DATA_WIDTH  memory (old) data, full bus word
- operand_b_i  in  DATA_WIDTH  AXI write data, full bus word
- tag_i  in  TAG_WIDTH  sideband
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts
- result_o  out  DATA_WIDTH  operand_a_i with lane bytes replaced by the op result
- strb_o  out  DATA_WIDTH/8  ones on lane bytes, zeros elsewhere
- tag_o  out  TAG_WIDTH  tag of the result
- err_o  out  1  illegal operation flag (feature only; tie 0 otherwise)

Behaviour:
- Reset: all stage valid bits 0; out_valid_o=0; result_o, strb_o, tag_o, err_o = 0. Reset mid-operation drops all in-flight operations without any output.
- Lane extraction: lane = bytes [addr_off_i +: 2**size_i] of each operand, zero-extended to DATA_WIDTH for unsigned ops and sign-extended from lane MSB for signed ops. addr_off_i is treated as aligned; low bits below size are ignored.
- Op decode:
  - ATOP[5:4]=11 with [3:0]=0000 is SWAP → lane result = b.
  - ATOP[5:4] ∈ {01 store, 10 load} → [2:0] selects the operation:
    - ADD 000: sum modulo lane width; no carry leaves the lane.
    - CLR 001: a&~b.
    - EOR 010: a^b.
    - SET 011: a|b.
    - SMAX 100 / SMIN 101: signed compare on the sign-extended lane.
    - UMAX 110 / UMIN 111: unsigned compare on the zero-extended lane.
    - Equality under any compare returns a.
  - Compare is a DATA_WIDTH+1-bit subtract a-b, with the sign bit selecting the result, identical for all lane sizes.
  - Anything else (ATOP none, CMP, ATOP[3]=1 big-endian) → lane result = a, strb all-zero.
- Merge: result_o = operand_a_i outside the lane, lane result inside.
- Pipeline:
  - Each stage holds valid plus payload.
  - Stage advances when its successor is empty or accepting: ready_k = !valid_k | ready_{k+1}; in_ready_o = ready_0.
  - Combinational ready path, no bubbles: full throughput of 1 op/cycle with out_ready_i held high.
  - Latency exactly PIPE_STAGES cycles from accept to out_valid_o.
  - Strict in-order delivery.
  - Outputs stable while out_valid_o=1 and out_ready_i=0.
- PIPE_STAGES=0: outputs combinational from inputs; in_ready_o = out_ready_i; out_valid_o = in_valid_i.
- Compare/add stage placement: the arithmetic is computed before the first register; later stages only delay.

Optional Feature:
- Macro: AXI_RISCV_AMOS_ALU_ILLEGAL_CHECK_EN.
- Defined:
  - err_o is asserted with the result of any op that is unsupported, has size_i > log2(DATA_WIDTH/8), or has addr_off_i misaligned to size.
  - That result has result_o = operand_a_i and strb_o = 0.
- Undefined: no checking logic; err_o tied 0; oversize ops are truncated to the full bus width.

Decomposition:
- Package axi_riscv_amos_pkg:
  - amo_lane_op_e: ADD, CLR, EOR, SET, SMAX, SMIN, UMAX, UMIN, SWAP, NOP.
  - Decode function from ATOP to amo_lane_op_e.
  - Payload struct typedef, parametrised via type parameter in the module.
- Sub-module axi_riscv_amos_lane_alu: combinational lane extract/compute/merge; the top module owns the pipeline registers.

Test Plan:
- SMAX, DATA_WIDTH=64, size=2, off=4, a=0x80000000_00000001, b=0x00000001_00000000 → result 0x00000001_00000001, strb 0xF0.
- Same stimulus as UMAX → result 0x80000000_00000001, strb 0xF0.
- ADD, size=0, off=0, a=0x00000000_000012FF, b=0x00000000_00000001 → result 0x00000000_00001200 (no carry into byte1), strb 0x01.
- PIPE_STAGES=2, out_ready_i=0, drive 3 back-to-back ops with tags 1,2,3:
  - in_ready_o drops after 2 accepts.
  - Release out_ready_i → tags 1,2,3 in order, one per cycle, third accepted the cycle ready frees.
- Assert rst_ni low while 2 ops in flight → out_valid_o=0 immediately; no stale result after reset release.
- With AXI_RISCV_AMOS_ALU_ILLEGAL_CHECK_EN, ATOP CMP (0x31) → err_o=1, result_o=operand_a_i, strb_o=0.
